alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Execute-stage front end; drives the 32-bit ALU's ctrl/op1/op2 inputs and consumes its result/overflow outputs.
- Accepts decoded MIPS instructions over a valid/ready handshake, translates opcode/funct into the 4-bit ALU control code, and selects the operands.
- Registers the ALU outcome into a writeback output stage that supports backpressure.
- Converts ALU overflow and illegal encodings into a blocking exception that software must acknowledge.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- ILLEGAL_TRAP, 1, 1 = an unknown encoding raises an exception; 0 = it retires silently with no write.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when in_valid && in_ready at the clock edge.
- in_opcode  in  6  instruction opcode.
- in_funct  in  6  R-type function field.
- in_shamt  in  5  shift amount.
- in_imm  in  16  I-type immediate.
- in_rs_val  in  32  rs register value.
- in_rt_val  in  32  rt register value.
- in_rd_idx  in  5  rd index.
- in_rt_idx  in  5  rt index.
- alu_ctrl  out  4  to ALU ctrl.
- alu_op1  out  32  to ALU op1.
- alu_op2  out  32  to ALU op2.
- alu_result  in  32  from ALU, combinational.
- alu_overflow  in  1  from ALU, combinational.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_result  out  32  value to write.
- out_dst  out  5  destination register.
- out_wr_en  out  1  1 = write the register file.
- exc_valid  out  1  exception pending.
- exc_code  out  2  exception cause: 1 = overflow, 2 = illegal.
- exc_ack  in  1  clears a pending exception.

Behaviour:
- Reset (async, rst_n = 0):
  - s1_valid = 0 and the state is RUN.
  - Outputs go to zero: out_valid = 0, out_result = 0, out_dst = 0, out_wr_en = 0, exc_valid = 0, exc_code = 0.
  - alu_ctrl/alu_op1/alu_op2 = 0.
- Pipeline:
  - Stage 1 (S1) registers the accepted instruction.
  - The ALU is driven combinationally from S1.
  - Stage 2 is the output register.
- Decode (ALU ctrl code, op1, op2), opcode 0x00 (R-type):
  - ADD 0x20 → 0, rs, rt.
  - ADDU 0x21 → 2, rs, rt.
  - SUB 0x22 → 1, rs, rt.
  - SUBU 0x23 → 3, rs, rt.
  - AND 0x24 → 4, rs, rt.
  - OR 0x25 → 5, rs, rt.
  - SLT 0x2A → 8, rs, rt.
  - SLL 0x00 → 6, rt, zero-extended shamt.
  - SRL 0x02 → 7, rt, zero-extended shamt.
  - R-type destination is rd.
- Decode, I-type (destination is in_rt_idx):
  - ADDI 0x08 → 0, rs, sign-extended imm.
  - ADDIU 0x09 → 2, rs, sign-extended imm.
  - SLTI 0x0A → 8, rs, sign-extended imm.
  - ANDI 0x0C → 4, rs, zero-extended imm.
  - ORI 0x0D → 5, rs, zero-extended imm.
- Any other encoding: illegal; alu_ctrl = 15, op1/op2 = 0.
- When S1 is empty, alu_ctrl/op1/op2 hold their last values. They are don't-care for correctness but must not be X after reset.
- Advance:
  - s1_adv = s1_valid && (!out_valid || out_ready).
  - On s1_adv: out_valid = 1, out_result = alu_result, out_dst, and out_wr_en = 1 unless the instruction traps.
  - On out_ready with no advance: out_valid clears.
- Trap condition:
  - alu_overflow = 1 with ctrl ∈ {0, 1}, or
  - illegal encoding with ILLEGAL_TRAP = 1.
  - Overflow from ADDU/SUBU/ADDIU is ignored.
- Trapping instruction on advance:
  - Still retires with out_valid = 1 and out_wr_en = 0; out_result = alu_result.
  - exc_valid = 1, exc_code is set, and the FSM moves RUN → TRAP.
- in_ready = (state == RUN) && !(s1_valid && s1_trap) && (!s1_valid || s1_adv).
  - No instruction is accepted in the cycle a trap retires, or while in TRAP.
  - Throughput is 1 instruction/cycle when out_ready = 1.
- TRAP state:
  - in_ready = 0.
  - exc_ack = 1 at an edge → exc_valid = 0, exc_code = 0, state = RUN.
  - in_ready may go high the following cycle.
  - exc_ack in RUN is ignored.
- Latency: an instruction accepted at edge N has out_valid = 1 after edge N+1. out_result/out_dst/out_wr_en stay stable while out_valid && !out_ready.
- Arithmetic:
  - Shifts use only the zero-extended 5-bit shamt, so shifts are 0–31.
  - Sign-extension copies imm[15] into bits 31:16.
- Reset mid-operation: S1 and the output entry are discarded, and any pending exception is cleared.

Test Plan:
- Throughput: ADDI rs = 5, imm = 0xFFFD; then OR rs = 0xF0, rt = 0x0F (rd = 7); out_ready = 1 → cycle 1 out_result = 2, wr_en = 1, dst = in_rt_idx; next cycle out_result = 0xFF, dst = 7; in_ready stays 1.
- Overflow: ADD rs = 0x7FFFFFFF, rt = 1 → out_wr_en = 0, out_result = 0x80000000, exc_valid = 1, exc_code = 1, in_ready = 0. Hold 5 cycles, pulse exc_ack → exc_valid = 0 and in_ready = 1 the next cycle. ADDU with the same operands → wr_en = 1, no exception.
- Illegal: opcode 0x3F with ILLEGAL_TRAP = 1 → exc_code = 2, wr_en = 0, alu_ctrl = 15. With ILLEGAL_TRAP = 0 → retires with wr_en = 0, no exc_valid.
- Backpressure: out_ready = 0 with three back-to-back SLL rt = 1, shamt = 4, 8, 31. Expect the first in output, the second in S1, and in_ready = 0. Release out_ready → results 0x10, 0x100, 0x80000000 in order, none lost or duplicated.
- SLTI/ANDI extension: SLTI rs = 0xFFFFFFFF, imm = 0x0001 → 1. ANDI rs = 0xFFFFFFFF, imm = 0x8001 → 0x00008001.
- Reset: assert rst_n = 0 while out_valid = 1 and in TRAP → all outputs 0 immediately (async); after release in_ready = 1 and exc_valid = 0.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Execute-stage issue unit: decodes MIPS ALU instructions, drives the external ALU from
// stage 1, and retires results into a backpressured writeback register with trap handling.
module alu_issue_unit #(
  parameter int DATA_W       = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [4:0]        in_rd_idx,
  input  logic [4:0]        in_rt_idx,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_dst,
  output logic              out_wr_en,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  input  logic              exc_ack
);

  typedef enum logic {ST_RUN, ST_TRAP} state_t;

  localparam logic [3:0] CTRL_ADD  = 4'd0;
  localparam logic [3:0] CTRL_SUB  = 4'd1;
  localparam logic [3:0] CTRL_ADDU = 4'd2;
  localparam logic [3:0] CTRL_SUBU = 4'd3;
  localparam logic [3:0] CTRL_AND  = 4'd4;
  localparam logic [3:0] CTRL_OR   = 4'd5;
  localparam logic [3:0] CTRL_SLL  = 4'd6;
  localparam logic [3:0] CTRL_SRL  = 4'd7;
  localparam logic [3:0] CTRL_SLT  = 4'd8;
  localparam logic [3:0] CTRL_ILL  = 4'd15;

  localparam logic [1:0] EXC_OVF = 2'd1;
  localparam logic [1:0] EXC_ILL = 2'd2;

  state_t state_reg, state_next;

  logic              s1_valid_reg;
  logic [3:0]        s1_ctrl_reg;
  logic [DATA_W-1:0] s1_op1_reg;
  logic [DATA_W-1:0] s1_op2_reg;
  logic [4:0]        s1_dst_reg;
  logic              s1_illegal_reg;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_result_reg;
  logic [4:0]        out_dst_reg;
  logic              out_wr_en_reg;

  logic              exc_valid_reg, exc_valid_next;
  logic [1:0]        exc_code_reg, exc_code_next;

  logic [3:0]        dec_ctrl;
  logic [DATA_W-1:0] dec_op1;
  logic [DATA_W-1:0] dec_op2;
  logic [4:0]        dec_dst;
  logic              dec_illegal;

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] shamt_zext;

  logic s1_trap;
  logic s1_adv;
  logic accept;

  assign imm_sext   = {{(DATA_W-16){in_imm[15]}}, in_imm};
  assign imm_zext   = {{(DATA_W-16){1'b0}}, in_imm};
  assign shamt_zext = {{(DATA_W-5){1'b0}}, in_shamt};

  // Decode happens on the incoming instruction so S1 holds ready-to-use ALU inputs.
  always_comb begin
    dec_ctrl    = CTRL_ILL;
    dec_op1     = '0;
    dec_op2     = '0;
    dec_dst     = in_rt_idx;
    dec_illegal = 1'b1;
    if (in_opcode == 6'h00) begin
      dec_dst = in_rd_idx;
      case (in_funct)
        6'h20: begin dec_ctrl = CTRL_ADD;  dec_op1 = in_rs_val; dec_op2 = in_rt_val;  dec_illegal = 1'b0; end
        6'h21: begin dec_ctrl = CTRL_ADDU; dec_op1 = in_rs_val; dec_op2 = in_rt_val;  dec_illegal = 1'b0; end
        6'h22: begin dec_ctrl = CTRL_SUB;  dec_op1 = in_rs_val; dec_op2 = in_rt_val;  dec_illegal = 1'b0; end
        6'h23: begin dec_ctrl = CTRL_SUBU; dec_op1 = in_rs_val; dec_op2 = in_rt_val;  dec_illegal = 1'b0; end
        6'h24: begin dec_ctrl = CTRL_AND;  dec_op1 = in_rs_val; dec_op2 = in_rt_val;  dec_illegal = 1'b0; end
        6'h25: begin dec_ctrl = CTRL_OR;   dec_op1 = in_rs_val; dec_op2 = in_rt_val;  dec_illegal = 1'b0; end
        6'h2A: begin dec_ctrl = CTRL_SLT;  dec_op1 = in_rs_val; dec_op2 = in_rt_val;  dec_illegal = 1'b0; end
        6'h00: begin dec_ctrl = CTRL_SLL;  dec_op1 = in_rt_val; dec_op2 = shamt_zext; dec_illegal = 1'b0; end
        6'h02: begin dec_ctrl = CTRL_SRL;  dec_op1 = in_rt_val; dec_op2 = shamt_zext; dec_illegal = 1'b0; end
        default: ;
      endcase
    end else begin
      case (in_opcode)
        6'h08: begin dec_ctrl = CTRL_ADD;  dec_op1 = in_rs_val; dec_op2 = imm_sext; dec_illegal = 1'b0; end
        6'h09: begin dec_ctrl = CTRL_ADDU; dec_op1 = in_rs_val; dec_op2 = imm_sext; dec_illegal = 1'b0; end
        6'h0A: begin dec_ctrl = CTRL_SLT;  dec_op1 = in_rs_val; dec_op2 = imm_sext; dec_illegal = 1'b0; end
        6'h0C: begin dec_ctrl = CTRL_AND;  dec_op1 = in_rs_val; dec_op2 = imm_zext; dec_illegal = 1'b0; end
        6'h0D: begin dec_ctrl = CTRL_OR;   dec_op1 = in_rs_val; dec_op2 = imm_zext; dec_illegal = 1'b0; end
        default: ;
      endcase
    end
  end

  // Only signed add/sub overflow traps; the unsigned forms ignore the ALU flag.
  assign s1_trap = (s1_illegal_reg && ILLEGAL_TRAP) ||
                   (alu_overflow && (s1_ctrl_reg == CTRL_ADD || s1_ctrl_reg == CTRL_SUB));
  assign s1_adv   = s1_valid_reg && (!out_valid_reg || out_ready);
  assign in_ready = (state_reg == ST_RUN) && !(s1_valid_reg && s1_trap) &&
                    (!s1_valid_reg || s1_adv);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_ctrl_reg    <= '0;
      s1_op1_reg     <= '0;
      s1_op2_reg     <= '0;
      s1_dst_reg     <= '0;
      s1_illegal_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg   <= 1'b1;
      s1_ctrl_reg    <= dec_ctrl;
      s1_op1_reg     <= dec_op1;
      s1_op2_reg     <= dec_op2;
      s1_dst_reg     <= dec_dst;
      s1_illegal_reg <= dec_illegal;
    end else if (s1_adv) begin
      s1_valid_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_dst_reg    <= '0;
      out_wr_en_reg  <= 1'b0;
    end else if (s1_adv) begin
      out_valid_reg  <= 1'b1;
      out_result_reg <= alu_result;
      out_dst_reg    <= s1_dst_reg;
      out_wr_en_reg  <= !s1_trap && !s1_illegal_reg;
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  always_comb begin
    state_next     = state_reg;
    exc_valid_next = exc_valid_reg;
    exc_code_next  = exc_code_reg;
    case (state_reg)
      ST_RUN: begin
        if (s1_adv && s1_trap) begin
          state_next     = ST_TRAP;
          exc_valid_next = 1'b1;
          exc_code_next  = s1_illegal_reg ? EXC_ILL : EXC_OVF;
        end
      end
      ST_TRAP: begin
        if (exc_ack) begin
          state_next     = ST_RUN;
          exc_valid_next = 1'b0;
          exc_code_next  = '0;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      exc_valid_reg <= 1'b0;
      exc_code_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      exc_valid_reg <= exc_valid_next;
      exc_code_reg  <= exc_code_next;
    end
  end

  assign alu_ctrl   = s1_ctrl_reg;
  assign alu_op1    = s1_op1_reg;
  assign alu_op2    = s1_op2_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_dst    = out_dst_reg;
  assign out_wr_en  = out_wr_en_reg;
  assign exc_valid  = exc_valid_reg;
  assign exc_code   = exc_code_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: a behavioural ALU closes the loop, directed vectors
// push expected writebacks, and a monitor pops them as the DUT retires entries.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic [4:0]  in_rd_idx = '0;
  logic [4:0]  in_rt_idx = '0;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_dst;
  logic        out_wr_en;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic        exc_ack = 1'b0;

  // Second instance with silent illegal retirement
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [5:0]  b_in_opcode = '0;
  logic [3:0]  b_alu_ctrl;
  logic [31:0] b_alu_op1, b_alu_op2, b_alu_result;
  logic        b_alu_overflow;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [31:0] b_out_result;
  logic [4:0]  b_out_dst;
  logic        b_out_wr_en;
  logic        b_exc_valid;
  logic [1:0]  b_exc_code;

  int checks = 0;
  int errors = 0;
  int last_wait;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic v;
    r = '0;
    v = 1'b0;
    case (c)
      4'd0, 4'd2: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1, 4'd3: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = {31'b0, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  always_comb {alu_overflow, alu_result} = alu_model(alu_ctrl, alu_op1, alu_op2);
  always_comb {b_alu_overflow, b_alu_result} = alu_model(b_alu_ctrl, b_alu_op1, b_alu_op2);

  alu_issue_unit #(.DATA_W(32), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_rd_idx(in_rd_idx), .in_rt_idx(in_rt_idx),
    .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dst(out_dst), .out_wr_en(out_wr_en),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_ack(exc_ack)
  );

  alu_issue_unit #(.DATA_W(32), .ILLEGAL_TRAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_opcode(b_in_opcode), .in_funct(6'h00), .in_shamt(5'd0), .in_imm(16'h0000),
    .in_rs_val(32'h1), .in_rt_val(32'h2), .in_rd_idx(5'd4), .in_rt_idx(5'd4),
    .alu_ctrl(b_alu_ctrl), .alu_op1(b_alu_op1), .alu_op2(b_alu_op2),
    .alu_result(b_alu_result), .alu_overflow(b_alu_overflow),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_dst(b_out_dst), .out_wr_en(b_out_wr_en),
    .exc_valid(b_exc_valid), .exc_code(b_exc_code), .exc_ack(1'b0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // Enter at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] rd, input logic [4:0] rti,
                      input logic [31:0] e_res, input logic [4:0] e_dst, input logic e_wr);
    bit accepted = 0;
    in_opcode = opc; in_funct = fn; in_shamt = sh; in_imm = imm;
    in_rs_val = rs; in_rt_val = rt; in_rd_idx = rd; in_rt_idx = rti;
    in_valid = 1'b1;
    last_wait = 0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      #1;
      if (in_ready) begin
        accepted = 1;
        sb.push_back('{res: e_res, dst: e_dst, wr: e_wr});
      end else begin
        last_wait++;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: opcode 0x%02h never accepted", opc);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got res=0x%08h dst=%0d wr=%0b, expected none",
                 out_result, out_dst, out_wr_en);
      end else begin
        mon_e = sb.pop_front();
        if (out_result !== mon_e.res || out_dst !== mon_e.dst || out_wr_en !== mon_e.wr) begin
          errors++;
          $display("FAIL sb_entry: got res=0x%08h dst=%0d wr=%0b, expected res=0x%08h dst=%0d wr=%0b",
                   out_result, out_dst, out_wr_en, mon_e.res, mon_e.dst, mon_e.wr);
        end
      end
    end
  end

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_dst", {27'b0, out_dst}, 32'd0);
    chk("rst_out_wr_en", {31'b0, out_wr_en}, 32'd0);
    chk("rst_exc", {29'b0, exc_valid, exc_code}, 32'd0);
    chk("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
    chk("rst_alu_ops", alu_op1 | alu_op2, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    // Throughput
    out_ready = 1'b1;
    send(6'h08, 6'h00, 5'd0, 16'hFFFD, 32'd5, 32'd0, 5'd0, 5'd3, 32'd2, 5'd3, 1'b1);
    send(6'h00, 6'h25, 5'd0, 16'h0000, 32'hF0, 32'h0F, 5'd7, 5'd1, 32'hFF, 5'd7, 1'b1);
    chk("tput_no_stall", last_wait, 32'd0);
    idle(3);

    // Exception on ignored ack in RUN
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
    #1 chk("ack_in_run_ignored", {30'b0, exc_valid, in_ready}, 32'd1);
    @(negedge clk);

    // Overflow trap
    send(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'd1, 5'd9, 5'd2, 32'h80000000, 5'd9, 1'b0);
    in_valid = 1'b0;
    #1 chk("ovf_s1_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("ovf_hold_exc", {29'b0, exc_valid, exc_code}, 32'b101);
      chk("ovf_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
    #1 chk("ovf_ack_exc", {29'b0, exc_valid, exc_code}, 32'd0);
    chk("ovf_ack_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    send(6'h00, 6'h21, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'd1, 5'd9, 5'd2, 32'h80000000, 5'd9, 1'b1);
    idle(2);
    #1 chk("addu_no_exc", {31'b0, exc_valid}, 32'd0);
    @(negedge clk);

    // Illegal trap
    send(6'h3F, 6'h00, 5'd0, 16'h0000, 32'h11, 32'h22, 5'd6, 5'd6, 32'd0, 5'd6, 1'b0);
    in_valid = 1'b0;
    #1 chk("ill_alu_ctrl", {28'b0, alu_ctrl}, 32'd15);
    chk("ill_alu_ops", alu_op1 | alu_op2, 32'd0);
    @(negedge clk);
    #1 chk("ill_exc", {29'b0, exc_valid, exc_code}, 32'b110);
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
    #1 chk("ill_ack_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    // Backpressure
    out_ready = 1'b0;
    send(6'h00, 6'h00, 5'd4, 16'h0000, 32'd0, 32'd1, 5'd10, 5'd0, 32'h10, 5'd10, 1'b1);
    send(6'h00, 6'h00, 5'd8, 16'h0000, 32'd0, 32'd1, 5'd11, 5'd0, 32'h100, 5'd11, 1'b1);
    fork
      send(6'h00, 6'h00, 5'd31, 16'h0000, 32'd0, 32'd1, 5'd12, 5'd0, 32'h80000000, 5'd12, 1'b1);
      begin
        #1 chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_result", out_result, 32'h10);
        chk("bp_s1_op2", alu_op2, 32'd8);
        @(negedge clk);
        #1 chk("bp_hold_result", out_result, 32'h10);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Extension and remaining ALU ops
    send(6'h0A, 6'h00, 5'd0, 16'h0001, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd13, 32'd1, 5'd13, 1'b1);
    send(6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd14, 32'h00008001, 5'd14, 1'b1);
    send(6'h00, 6'h22, 5'd0, 16'h0000, 32'd10, 32'd3, 5'd15, 5'd0, 32'd7, 5'd15, 1'b1);
    send(6'h00, 6'h02, 5'd31, 16'h0000, 32'd0, 32'h80000000, 5'd16, 5'd0, 32'd1, 5'd16, 1'b1);
    send(6'h00, 6'h24, 5'd0, 16'h0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd17, 5'd0, 32'h0F000F00, 5'd17, 1'b1);
    send(6'h00, 6'h2A, 5'd0, 16'h0000, 32'hFFFFFFFE, 32'd1, 5'd18, 5'd0, 32'd1, 5'd18, 1'b1);
    idle(4);
    chk("drain_mid", sb.size(), 32'd0);

    // Async reset while holding a trapped entry
    out_ready = 1'b0;
    send(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'd1, 5'd20, 5'd0, 32'h80000000, 5'd20, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("pre_rst_state", {30'b0, exc_valid, out_valid}, 32'b11);
    rst_n = 1'b0;
    #1 chk("async_rst_outs", {26'b0, out_valid, out_wr_en, exc_valid, exc_code}, 32'd0);
    chk("async_rst_result", out_result | {27'b0, out_dst}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("rst_release_ready", {30'b0, in_ready, exc_valid}, 32'b10);
    @(negedge clk);

    // Illegal with silent retirement
    b_in_opcode = 6'h3F;
    b_in_valid = 1'b1;
    #1 chk("b_in_ready", {31'b0, b_in_ready}, 32'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1 chk("b_alu_ctrl", {28'b0, b_alu_ctrl}, 32'd15);
    @(negedge clk);
    #1 chk("b_retire", {29'b0, b_out_valid, b_out_wr_en, b_exc_valid}, 32'b100);
    chk("b_in_ready_after", {31'b0, b_in_ready}, 32'd1);
    @(negedge clk);
    #1 chk("b_no_exc", {29'b0, b_exc_valid, b_exc_code}, 32'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
